// File: rtl/packet_sync_gen.sv
// TX-path AXI-stream pass-through that inserts one 64-byte VLAN-tagged sync beat at packet boundaries.
// Optional macro PACKET_SYNC_GEN_TIMESTAMP_EN adds a 64-bit cycle-count timestamp to the sync frame.
//
// state | meaning
// IDLE  | between packets; pass-through unless a sync is pending
// PASS  | mid-packet pass-through; pending syncs wait for tlast
// SYNC  | presenting the sync frame until m_axis_tready
module packet_sync_gen #(
   parameter logic [11:0] VLAN_ID     = 12'hABC,
   parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC     = 48'h0000_0000_0000,
   parameter logic [15:0] INNER_ETYPE = 16'h88B5,
   parameter int unsigned SYNC_PERIOD = 0
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         s_axis_tvalid,
   input  logic [511:0] s_axis_tdata,
   input  logic [63:0]  s_axis_tkeep,
   input  logic         s_axis_tlast,
   input  logic [15:0]  s_axis_tuser,
   output logic         s_axis_tready,
   output logic         m_axis_tvalid,
   output logic [511:0] m_axis_tdata,
   output logic [63:0]  m_axis_tkeep,
   output logic         m_axis_tlast,
   output logic [15:0]  m_axis_tuser,
   input  logic         m_axis_tready,
   input  logic         sync_req_i,
   output logic         sync_sent_o,
   output logic [31:0]  sync_seq_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_SYNC} state_t;

   localparam logic [31:0] LP_PERIOD_LAST = (SYNC_PERIOD > 0) ? 32'(SYNC_PERIOD - 1) : 32'd0;

   state_t         r_state;
   logic           r_pending;
   logic [31:0]    r_seq;
   logic [31:0]    r_period_cnt;
   logic           r_sync_sent;
   logic [31:0]    r_sync_seq;

   logic           w_pass;
   logic           w_in_sync;
   logic           w_s_acc;
   logic           w_sync_acc;
   logic           w_wrap;
   logic           w_req;
   logic [63:0]    w_ts;
   logic [511:0]   w_frame;

   assign w_in_sync  = (r_state == ST_SYNC);
   assign w_pass     = (r_state == ST_PASS) || ((r_state == ST_IDLE) && !r_pending);
   assign w_s_acc    = s_axis_tvalid && s_axis_tready;
   assign w_sync_acc = w_in_sync && m_axis_tready;
   assign w_wrap     = (SYNC_PERIOD != 0) && (r_period_cnt == LP_PERIOD_LAST);
   assign w_req      = sync_req_i || w_wrap;

   // Valid/ready are gated by reset combinationally so nothing leaks out while held in reset.
   assign s_axis_tready = aresetn && w_pass && m_axis_tready;
   assign m_axis_tvalid = aresetn && (w_pass ? s_axis_tvalid : w_in_sync);
   assign m_axis_tdata  = w_in_sync ? w_frame : s_axis_tdata;
   assign m_axis_tkeep  = w_in_sync ? {64{1'b1}} : s_axis_tkeep;
   assign m_axis_tlast  = w_in_sync ? 1'b1 : s_axis_tlast;
   assign m_axis_tuser  = w_in_sync ? 16'd64 : s_axis_tuser;
   assign sync_sent_o   = r_sync_sent;
   assign sync_seq_o    = r_sync_seq;

   always_comb begin
      w_frame            = '0;
      w_frame[47:0]      = DST_MAC;
      w_frame[95:48]     = SRC_MAC;
      w_frame[111:96]    = 16'h8100;
      w_frame[115:112]   = 4'h0;
      w_frame[127:116]   = VLAN_ID;
      w_frame[143:128]   = INNER_ETYPE;
      w_frame[175:144]   = r_seq;
      w_frame[239:176]   = w_ts;
   end

`ifdef PACKET_SYNC_GEN_TIMESTAMP_EN
   logic [63:0] r_cycle_cnt;
   logic [63:0] r_ts;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_cycle_cnt <= '0;
         r_ts        <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + 64'd1;
         if ((r_state == ST_IDLE) && r_pending)
            r_ts <= r_cycle_cnt;
      end
   end

   assign w_ts = r_ts;
`else
   assign w_ts = '0;
`endif

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state      <= ST_IDLE;
         r_pending    <= 1'b0;
         r_seq        <= '0;
         r_period_cnt <= '0;
         r_sync_sent  <= 1'b0;
         r_sync_seq   <= '0;
      end else begin
         r_period_cnt <= ((SYNC_PERIOD == 0) || w_wrap) ? 32'd0 : r_period_cnt + 32'd1;
         // A request landing on the acceptance cycle keeps the flag set for another frame.
         r_pending    <= w_req || (r_pending && !w_sync_acc);
         r_sync_sent  <= w_sync_acc;
         case (r_state)
            ST_IDLE: begin
               if (r_pending)
                  r_state <= ST_SYNC;
               else if (w_s_acc && !s_axis_tlast)
                  r_state <= ST_PASS;
            end
            ST_PASS: begin
               if (w_s_acc && s_axis_tlast)
                  r_state <= ST_IDLE;
            end
            ST_SYNC: begin
               if (m_axis_tready) begin
                  r_state    <= ST_IDLE;
                  r_seq      <= r_seq + 32'd1;
                  r_sync_seq <= r_seq;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_packet_sync_gen.sv
// Directed bench for packet_sync_gen: vector table plus hand sequences for seq wrap,
// mid-packet reset with timestamp, and a periodic-sync instance.
module tb_packet_sync_gen;

   localparam logic [63:0] KEEP_IN = 64'h0000_FFFF_FFFF_FFFF;
   localparam logic [15:0] USER_IN = 16'd200;

   logic         aclk = 1'b0;
   always #2 aclk = ~aclk;

   logic         rstn;
   logic         s_valid;
   logic [511:0] s_data;
   logic         s_last;
   logic         s_ready;
   logic         m_valid;
   logic [511:0] m_data;
   logic [63:0]  m_keep;
   logic         m_last;
   logic [15:0]  m_user;
   logic         m_ready;
   logic         sync_req;
   logic         sync_sent;
   logic [31:0]  sync_seq;

   logic         p_rstn;
   logic         p_sready;
   logic         p_valid;
   logic [511:0] p_data;
   logic [63:0]  p_keep;
   logic         p_last;
   logic [15:0]  p_user;
   logic         p_sent;
   logic [31:0]  p_seq;
   logic         per_done;

   int n_err = 0;
   int n_chk = 0;

   packet_sync_gen dut (
      .aclk(aclk), .aresetn(rstn),
      .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tkeep(KEEP_IN),
      .s_axis_tlast(s_last), .s_axis_tuser(USER_IN), .s_axis_tready(s_ready),
      .m_axis_tvalid(m_valid), .m_axis_tdata(m_data), .m_axis_tkeep(m_keep),
      .m_axis_tlast(m_last), .m_axis_tuser(m_user), .m_axis_tready(m_ready),
      .sync_req_i(sync_req), .sync_sent_o(sync_sent), .sync_seq_o(sync_seq)
   );

   packet_sync_gen #(.SYNC_PERIOD(100)) u_per (
      .aclk(aclk), .aresetn(p_rstn),
      .s_axis_tvalid(1'b0), .s_axis_tdata(512'd0), .s_axis_tkeep(64'd0),
      .s_axis_tlast(1'b0), .s_axis_tuser(16'd0), .s_axis_tready(p_sready),
      .m_axis_tvalid(p_valid), .m_axis_tdata(p_data), .m_axis_tkeep(p_keep),
      .m_axis_tlast(p_last), .m_axis_tuser(p_user), .m_axis_tready(1'b1),
      .sync_req_i(1'b0), .sync_sent_o(p_sent), .sync_seq_o(p_seq)
   );

   typedef struct {
      logic        req, sv, sl, mr;
      logic [63:0] d;
      logic        ev, er, el, es;
      logic [31:0] eseq;
      logic        esent;
      logic [31:0] eseqo;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic req, sv, sl, mr, input logic [63:0] d,
                               input logic ev, er, el, es, input logic [31:0] eseq,
                               input logic esent, input logic [31:0] eseqo);
      vec_t v;
      v.req = req; v.sv = sv; v.sl = sl; v.mr = mr; v.d = d;
      v.ev = ev; v.er = er; v.el = el; v.es = es; v.eseq = eseq;
      v.esent = esent; v.eseqo = eseqo;
      return v;
   endfunction

   function automatic logic [511:0] frame(input logic [31:0] seq);
      logic [511:0] f;
      f          = '0;
      f[47:0]    = 48'hFFFF_FFFF_FFFF;
      f[111:96]  = 16'h8100;
      f[127:116] = 12'hABC;
      f[143:128] = 16'h88B5;
      f[175:144] = seq;
      return f;
   endfunction

   function automatic logic [511:0] mask_ts(input logic [511:0] x);
      logic [511:0] y;
      y          = x;
      y[239:176] = '0;
      return y;
   endfunction

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_sync(input string nm, input logic [31:0] es);
      int n;
      @(negedge aclk); sync_req = 1'b1;
      @(negedge aclk); sync_req = 1'b0;
      n = 0;
      while (!m_valid && n < 8) begin
         @(negedge aclk);
         n++;
      end
      chk({nm, " valid"}, m_valid, 1'b1);
      chk({nm, " seq field"}, m_data[175:144], es);
      chk({nm, " frame"}, mask_ts(m_data), frame(es));
      @(negedge aclk);
      chk({nm, " sent"}, sync_sent, 1'b1);
      chk({nm, " seq_o"}, sync_seq, es);
   endtask

   // Periodic instance: syncs must appear every 100 cycles carrying seq 0..3.
   initial begin
      int cyc, last_cyc, n;
      p_rstn = 1'b0; per_done = 1'b0; n = 0; cyc = 0; last_cyc = 0;
      repeat (2) @(negedge aclk);
      p_rstn = 1'b1;
      while (n < 4 && cyc < 600) begin
         @(negedge aclk);
         cyc++;
         if (p_valid) begin
            chk("per frame seq", p_data[175:144], n);
            chk("per frame hdr", mask_ts(p_data), frame(n));
            chk("per keep", p_keep, {64{1'b1}});
            chk("per last/user", {p_last, p_user}, {1'b1, 16'd64});
            chk("per s_ready", p_sready, 1'b0);
         end
         if (p_sent) begin
            chk("per seq_o", p_seq, n);
            if (n > 0) chk("per spacing", cyc - last_cyc, 100);
            last_cyc = cyc;
            n++;
         end
      end
      chk("per count", n, 4);
      per_done = 1'b1;
   end

   initial begin
      int n;
      rstn = 1'b0; s_valid = 1'b1; s_data = '0; s_last = 1'b0; m_ready = 1'b1; sync_req = 1'b0;

      // idle, then request at row 10
      for (int i = 0; i < 10; i++) tbl.push_back(mk(0,0,0,1,0, 0,1,0,0,0, 0,0));
      tbl.push_back(mk(1,0,0,1,0, 0,1,0,0,0, 0,0));
      tbl.push_back(mk(0,0,0,1,0, 0,0,0,0,0, 0,0));
      tbl.push_back(mk(0,0,0,1,0, 1,0,1,1,0, 0,0));
      tbl.push_back(mk(0,0,0,1,0, 0,1,0,0,0, 1,0));
      // 4-beat packet, request on beat 2, next packet waits behind the sync frame
      tbl.push_back(mk(0,1,0,1,64'hB1, 1,1,0,0,0, 0,0));
      tbl.push_back(mk(1,1,0,1,64'hB2, 1,1,0,0,0, 0,0));
      tbl.push_back(mk(0,1,0,1,64'hB3, 1,1,0,0,0, 0,0));
      tbl.push_back(mk(0,1,1,1,64'hB4, 1,1,1,0,0, 0,0));
      tbl.push_back(mk(0,1,0,1,64'hC1, 0,0,0,0,0, 0,0));
      tbl.push_back(mk(0,1,0,1,64'hC1, 1,0,1,1,1, 0,0));
      tbl.push_back(mk(0,1,0,1,64'hC1, 1,1,0,0,0, 1,1));
      tbl.push_back(mk(0,1,1,1,64'hC2, 1,1,1,0,0, 0,1));
      // stall 5 cycles in SYNC with three coalesced requests
      tbl.push_back(mk(1,0,0,1,0, 0,1,0,0,0, 0,1));
      tbl.push_back(mk(0,0,0,1,0, 0,0,0,0,0, 0,1));
      tbl.push_back(mk(1,0,0,0,0, 1,0,1,1,2, 0,1));
      tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,2, 0,1));
      tbl.push_back(mk(1,0,0,0,0, 1,0,1,1,2, 0,1));
      tbl.push_back(mk(0,0,0,0,0, 1,0,1,1,2, 0,1));
      tbl.push_back(mk(1,0,0,0,0, 1,0,1,1,2, 0,1));
      tbl.push_back(mk(0,0,0,1,0, 1,0,1,1,2, 0,1));
      tbl.push_back(mk(0,0,0,1,0, 0,1,0,0,0, 1,2));
      tbl.push_back(mk(0,0,0,1,0, 0,1,0,0,0, 0,2));
      tbl.push_back(mk(0,0,0,1,0, 0,1,0,0,0, 0,2));
      // request on the acceptance cycle keeps pending set
      tbl.push_back(mk(1,0,0,1,0, 0,1,0,0,0, 0,2));
      tbl.push_back(mk(0,0,0,1,0, 0,0,0,0,0, 0,2));
      tbl.push_back(mk(1,0,0,1,0, 1,0,1,1,3, 0,2));
      tbl.push_back(mk(0,0,0,1,0, 0,0,0,0,0, 1,3));
      tbl.push_back(mk(0,0,0,1,0, 1,0,1,1,4, 0,3));
      tbl.push_back(mk(0,0,0,1,0, 0,1,0,0,0, 1,4));

      repeat (3) @(negedge aclk);
      chk("reset m_valid", m_valid, 1'b0);
      chk("reset s_ready", s_ready, 1'b0);
      chk("reset sync_sent", sync_sent, 1'b0);
      chk("reset sync_seq", sync_seq, 32'd0);
      s_valid = 1'b0;
      rstn    = 1'b1;

      foreach (tbl[i]) begin
         @(negedge aclk);
         sync_req = tbl[i].req; s_valid = tbl[i].sv; s_last = tbl[i].sl;
         m_ready  = tbl[i].mr;  s_data  = {448'd0, tbl[i].d};
         #1;
         chk($sformatf("v%0d m_valid", i), m_valid, tbl[i].ev);
         chk($sformatf("v%0d s_ready", i), s_ready, tbl[i].er);
         chk($sformatf("v%0d sync_sent", i), sync_sent, tbl[i].esent);
         chk($sformatf("v%0d sync_seq", i), sync_seq, tbl[i].eseqo);
         if (tbl[i].ev) begin
            chk($sformatf("v%0d m_last", i), m_last, tbl[i].el);
            if (tbl[i].es) begin
               chk($sformatf("v%0d sync data", i), mask_ts(m_data), frame(tbl[i].eseq));
               chk($sformatf("v%0d sync keep", i), m_keep, {64{1'b1}});
               chk($sformatf("v%0d sync user", i), m_user, 16'd64);
            end else begin
               chk($sformatf("v%0d pass data", i), m_data, {448'd0, tbl[i].d});
               chk($sformatf("v%0d pass keep", i), m_keep, KEEP_IN);
               chk($sformatf("v%0d pass user", i), m_user, USER_IN);
            end
         end
      end

      @(negedge aclk);
      sync_req = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
      force dut.r_seq = 32'hFFFF_FFFF;
      @(negedge aclk);
      release dut.r_seq;
      do_sync("wrap_a", 32'hFFFF_FFFF);
      do_sync("wrap_b", 32'h0000_0000);

      // reset during beat 2 of a packet with a sync already pending
      @(negedge aclk);
      s_valid = 1'b1; s_data = {448'd0, 64'hD1}; s_last = 1'b0; sync_req = 1'b1;
      @(negedge aclk);
      sync_req = 1'b0; s_data = {448'd0, 64'hD2}; rstn = 1'b0;
      #1;
      chk("rst m_valid forced", m_valid, 1'b0);
      chk("rst s_ready forced", s_ready, 1'b0);
      @(negedge aclk);
      rstn = 1'b1; s_valid = 1'b0;
      #1;
      chk("post-rst m_valid", m_valid, 1'b0);
      chk("post-rst pending", dut.r_pending, 1'b0);
      chk("post-rst sync_seq", sync_seq, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge aclk);
         chk($sformatf("post-rst no sync %0d", k), m_valid, 1'b0);
      end
      sync_req = 1'b1;
      @(negedge aclk);
      sync_req = 1'b0;
      chk("post-rst latency idle", m_valid, 1'b0);
      @(negedge aclk);
      chk("post-rst sync valid", m_valid, 1'b1);
      chk("post-rst sync seq", m_data[175:144], 32'd0);
`ifdef PACKET_SYNC_GEN_TIMESTAMP_EN
      chk("post-rst timestamp", m_data[239:176], 64'd4);
`else
      chk("post-rst timestamp", m_data[239:176], 64'd0);
`endif
      @(negedge aclk);
      chk("post-rst sent", sync_sent, 1'b1);
      chk("post-rst seq_o", sync_seq, 32'd0);

      n = 0;
      while (!per_done && n < 1000) begin
         @(negedge aclk);
         n++;
      end
      if (!per_done) chk("per timeout", per_done, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
